// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues requests to a synchronous
// instruction memory, buffers returned words and presents the head entry to the
// IF/ID pipeline register. Redirect has priority over everything, including Stall.
module if_fetch_unit #(
    parameter int              PCW      = 9,
    parameter int              IW       = 32,
    parameter int              DEPTH    = 2,
    parameter logic [PCW-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            Stall,
    input  logic            Redirect,
    input  logic [PCW-1:0]  RedirectPC,
    output logic            ImemReq,
    output logic [PCW-1:0]  ImemAddr,
    input  logic [IW-1:0]   ImemRdata,
    output logic            InstrValid,
    output logic [PCW-1:0]  PC,
    output logic [PCW-1:0]  PCPlus4,
    output logic [IW-1:0]   Instr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PCW-1:0] fetch_pc_q, fetch_pc_d;
    logic           in_flight_q, in_flight_d;
    logic [PCW-1:0] in_flight_pc_q, in_flight_pc_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]  count_q, count_d;

    // PC+4 is stored per entry so the head outputs come purely from flops.
    logic [PCW-1:0] buf_pc_q    [DEPTH];
    logic [PCW-1:0] buf_pc_d    [DEPTH];
    logic [PCW-1:0] buf_pc4_q   [DEPTH];
    logic [PCW-1:0] buf_pc4_d   [DEPTH];
    logic [IW-1:0]  buf_instr_q [DEPTH];
    logic [IW-1:0]  buf_instr_d [DEPTH];

    logic           pop;
    logic           enq;
    logic           req;
    logic [CW-1:0]  occupancy;

    // Address bits [1:0] of the redirect target are ignored.
    logic [1:0]     unused_redirect_lsbs;
    assign unused_redirect_lsbs = RedirectPC[1:0];

    // Handshake decisions: consume, capture returning data, and request gating.
    always_comb begin
        InstrValid = (count_q != '0);
        pop        = InstrValid & ~Stall & ~Redirect;
        enq        = in_flight_q & ~Redirect;
        // Entries that will be owed once this cycle's pop happens; a new request
        // is only issued if its data is guaranteed a free slot.
        occupancy  = count_q + CW'(in_flight_q) - CW'(pop);
        req        = reset & ~Redirect & (occupancy < CW'(DEPTH));
        ImemReq    = req;
        ImemAddr   = fetch_pc_q;
        PC         = buf_pc_q[rd_ptr_q];
        PCPlus4    = buf_pc4_q[rd_ptr_q];
        Instr      = buf_instr_q[rd_ptr_q];
    end

    // Next-state for fetch PC, outstanding-request record and holding buffer.
    always_comb begin
        fetch_pc_d     = fetch_pc_q;
        in_flight_d    = req;
        in_flight_pc_d = in_flight_pc_q;
        rd_ptr_d       = rd_ptr_q;
        wr_ptr_d       = wr_ptr_q;
        count_d        = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            buf_pc_d[i]    = buf_pc_q[i];
            buf_pc4_d[i]   = buf_pc4_q[i];
            buf_instr_d[i] = buf_instr_q[i];
        end

        if (Redirect) begin
            fetch_pc_d = {RedirectPC[PCW-1:2], 2'b00};
            // Empty the buffer without moving the read pointer so the stale
            // head outputs simply hold their last values.
            wr_ptr_d   = rd_ptr_q;
            count_d    = '0;
        end else begin
            if (req) begin
                fetch_pc_d     = fetch_pc_q + PCW'(4);
                in_flight_pc_d = fetch_pc_q;
            end
            if (enq) begin
                buf_pc_d[wr_ptr_q]    = in_flight_pc_q;
                buf_pc4_d[wr_ptr_q]   = in_flight_pc_q + PCW'(4);
                buf_instr_d[wr_ptr_q] = ImemRdata;
                wr_ptr_d              = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(enq) - CW'(pop);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q     <= RESET_PC;
            in_flight_q    <= 1'b0;
            in_flight_pc_q <= '0;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            count_q        <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_pc_q[i]    <= '0;
                buf_pc4_q[i]   <= '0;
                buf_instr_q[i] <= '0;
            end
        end else begin
            fetch_pc_q     <= fetch_pc_d;
            in_flight_q    <= in_flight_d;
            in_flight_pc_q <= in_flight_pc_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            count_q        <= count_d;
            buf_pc_q       <= buf_pc_d;
            buf_pc4_q      <= buf_pc4_d;
            buf_instr_q    <= buf_instr_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: random Stall/Redirect/reset traffic,
// expected instruction stream kept in a scoreboard queue, checked by a monitor.
module tb_if_fetch_unit;

    localparam int             PCW      = 9;
    localparam int             IW       = 32;
    localparam int             DEPTH    = 2;
    localparam logic [PCW-1:0] RESET_PC = 9'h000;

    logic           clk;
    logic           reset;
    logic           Stall;
    logic           Redirect;
    logic [PCW-1:0] RedirectPC;
    logic           ImemReq;
    logic [PCW-1:0] ImemAddr;
    logic [IW-1:0]  ImemRdata;
    logic           InstrValid;
    logic [PCW-1:0] PC;
    logic [PCW-1:0] PCPlus4;
    logic [IW-1:0]  Instr;

    if_fetch_unit #(
        .PCW(PCW), .IW(IW), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .reset(reset), .Stall(Stall), .Redirect(Redirect),
        .RedirectPC(RedirectPC), .ImemReq(ImemReq), .ImemAddr(ImemAddr),
        .ImemRdata(ImemRdata), .InstrValid(InstrValid), .PC(PC),
        .PCPlus4(PCPlus4), .Instr(Instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [PCW-1:0] pc;
        logic [IW-1:0]  instr;
    } exp_t;

    exp_t           exp_q[$];
    logic [PCW-1:0] gen_pc;
    int             vectors     = 0;
    int             miscompares = 0;

    // Memory contents: word i holds i.
    function automatic logic [IW-1:0] imem_word(input logic [PCW-1:0] a);
        return IW'(a[PCW-1:2]);
    endfunction

    // Synchronous memory: data one cycle after the request, junk otherwise.
    always @(posedge clk) begin
        if (ImemReq) ImemRdata <= imem_word(ImemAddr);
        else         ImemRdata <= $urandom;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic topup();
        while (exp_q.size() < 8) begin
            exp_q.push_back('{pc: gen_pc, instr: imem_word(gen_pc)});
            gen_pc = gen_pc + 9'd4;
        end
    endtask

    task automatic restart(input logic [PCW-1:0] pc);
        exp_q.delete();
        gen_pc = {pc[PCW-1:2], 2'b00};
        topup();
    endtask

    task automatic cycle(input bit s, input bit r, input logic [PCW-1:0] rpc);
        @(posedge clk);
        #1;
        Stall      = s;
        Redirect   = r;
        RedirectPC = rpc;
        if (r) restart(rpc);
        topup();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset    = 1'b0;
        Stall    = 1'b0;
        Redirect = 1'b0;
        restart(RESET_PC);
        #1;
        check("rst_req",    32'(ImemReq),    32'd0);
        check("rst_addr",   32'(ImemAddr),   32'(RESET_PC));
        check("rst_valid",  32'(InstrValid), 32'd0);
        check("rst_pc",     32'(PC),         32'd0);
        check("rst_pcplus4",32'(PCPlus4),    32'd0);
        check("rst_instr",  Instr,           32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Monitor: restart latency, continuity, stall back-pressure, head contents.
    int             age       = 0;
    int             stall_run = 0;
    logic [PCW-1:0] target    = RESET_PC;
    always @(negedge clk) begin
        if (!reset) begin
            check("req_in_reset",   32'(ImemReq),    32'd0);
            check("valid_in_reset", 32'(InstrValid), 32'd0);
            age       = 0;
            stall_run = 0;
            target    = RESET_PC;
        end else begin
            age++;
            if (Stall && !Redirect) stall_run++;
            else                    stall_run = 0;
            if (age == 1 && !Redirect) begin
                check("restart_req",  32'(ImemReq),  32'd1);
                check("restart_addr", 32'(ImemAddr), 32'(target));
            end
            if (age == 1 || age == 2) check("restart_bubble", 32'(InstrValid), 32'd0);
            if (age >= 3)             check("continuous_valid", 32'(InstrValid), 32'd1);
            if (stall_run >= 4 && age >= 4) check("stall_req_off", 32'(ImemReq), 32'd0);
            if (Redirect) begin
                check("redirect_req_off", 32'(ImemReq), 32'd0);
                target = {RedirectPC[PCW-1:2], 2'b00};
                age    = 0;
            end else if (InstrValid) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL head_unexpected: got PC 'h%0h expected no instruction", PC);
                end else begin
                    exp_t           e;
                    logic [PCW-1:0] e4;
                    e  = exp_q[0];
                    e4 = e.pc + 9'd4;
                    check("head_pc",      32'(PC),      32'(e.pc));
                    check("head_pcplus4", 32'(PCPlus4), 32'(e4));
                    check("head_instr",   Instr,        e.instr);
                    if (!Stall) void'(exp_q.pop_front());
                end
            end
        end
    end

    // Stimulus: directed scenarios, then randomized traffic.
    initial begin
        reset      = 1'b0;
        Stall      = 1'b0;
        Redirect   = 1'b0;
        RedirectPC = '0;
        restart(RESET_PC);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        repeat (3) cycle(1'b0, 1'b0, '0);
        repeat (5) cycle(1'b1, 1'b0, '0);
        repeat (6) cycle(1'b0, 1'b0, '0);

        cycle(1'b0, 1'b1, 9'h041);
        repeat (6) cycle(1'b0, 1'b0, '0);

        cycle(1'b1, 1'b1, 9'h0A3);
        repeat (6) cycle(1'b0, 1'b0, '0);

        cycle(1'b0, 1'b1, 9'h1F8);
        repeat (6) cycle(1'b0, 1'b0, '0);

        cycle(1'b0, 1'b1, 9'h100);
        cycle(1'b0, 1'b1, 9'h020);
        cycle(1'b0, 1'b1, 9'h1FE);
        repeat (6) cycle(1'b0, 1'b0, '0);

        repeat (4) cycle(1'b1, 1'b0, '0);
        do_reset();
        repeat (8) cycle(1'b0, 1'b0, '0);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 9) < 3,
                      $urandom_range(0, 19) == 0,
                      PCW'($urandom));
            end
        end
        repeat (4) cycle(1'b0, 1'b0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
